// File: rtl/pwm_multi.sv
// pwm_multi: NCH-channel PWM sharing one period counter, with double-buffered duty registers.
// Define PWM_CENTER_EN to build the center-aligned (up/down) counting mode selected by 'center'.
module pwm_multi #(
   parameter int NCH   = 4,
   parameter int CBITS = 21,
   localparam int LW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CBITS-1:0] period,
   input  logic             center,
   input  logic             load_valid,
   input  logic [LW-1:0]    load_ch,
   input  logic [CBITS-1:0] load_duty,
   output logic             load_ready,
   output logic [NCH-1:0]   pwm,
   output logic             period_tick
);

   localparam logic [CBITS-1:0] ONE = CBITS'(1);

   logic [CBITS-1:0] cnt;
   logic [CBITS-1:0] cnt_nxt;
   logic [CBITS-1:0] per_q;
   logic [CBITS-1:0] top;
   logic [CBITS-1:0] dact  [NCH];
   logic [CBITS-1:0] dpend [NCH];
   logic [NCH-1:0]   pf;
   logic             run;
   logic             wrap;
   logic             xfer;
   logic             accept;

   // Periods of 0 or 1 count never run: counter parked, outputs low, no ticks.
   assign top    = per_q - ONE;
   assign run    = en && (per_q > ONE);
   assign xfer   = !en || wrap;
   assign accept = load_valid && load_ready;

   always_comb begin
      load_ready = 1'b0;
      for (int i = 0; i < NCH; i++)
         if (load_ch == LW'(i)) load_ready = !pf[i];
   end

`ifdef PWM_CENTER_EN
   // state  | meaning
   // DIR_UP | counting up 0 .. per_q-1 (edge mode stays here)
   // DIR_DN | counting down per_q-2 .. 1, wrap at 1
   typedef enum logic {DIR_UP, DIR_DN} dir_t;

   dir_t dir;
   dir_t dir_nxt;
   logic center_q;

   always_comb begin
      cnt_nxt = cnt;
      dir_nxt = dir;
      wrap    = 1'b0;
      if (!run) begin
         cnt_nxt = '0;
         dir_nxt = DIR_UP;
      end else if (dir == DIR_DN) begin
         if (cnt == ONE) begin
            wrap    = 1'b1;
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
         end else begin
            cnt_nxt = cnt - ONE;
         end
      end else if (cnt == top) begin
         // A 2-count center period has no down slope; the top is also the wrap.
         if (!center_q || cnt == ONE) begin
            wrap    = 1'b1;
            cnt_nxt = '0;
         end else begin
            dir_nxt = DIR_DN;
            cnt_nxt = cnt - ONE;
         end
      end else begin
         cnt_nxt = cnt + ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir      <= DIR_UP;
         center_q <= 1'b0;
      end else begin
         dir <= dir_nxt;
         if (xfer) center_q <= center;
      end
   end
`else
   logic center_unused;
   assign center_unused = center;

   always_comb begin
      cnt_nxt = cnt;
      wrap    = 1'b0;
      if (!run) begin
         cnt_nxt = '0;
      end else if (cnt == top) begin
         wrap    = 1'b1;
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + ONE;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         per_q       <= '0;
         pf          <= '0;
         pwm         <= '0;
         period_tick <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            dact[i]  <= '0;
            dpend[i] <= '0;
         end
      end else begin
         cnt         <= cnt_nxt;
         period_tick <= run && (cnt == '0);
         if (xfer) per_q <= period;
         for (int i = 0; i < NCH; i++) begin
            pwm[i] <= run && (cnt < dact[i]);
            if (xfer && pf[i]) begin
               dact[i] <= dpend[i];
               pf[i]   <= 1'b0;
            end
            // A write accepted in a wrap cycle lands after the transfer and stays pending.
            if (accept && load_ch == LW'(i)) begin
               dpend[i] <= load_duty;
               pf[i]    <= 1'b1;
            end
         end
      end
   end

endmodule
